// File: rtl/rx_nrzi_destuff_if.sv
// Line-side and counter-side signal bundle for the NRZI decode / bit de-stuff stage.
// The master side is whoever owns the line sampler and packet control; the slave
// side is the de-stuff block, which returns the accepted-bit stream.
interface rx_nrzi_destuff_if;
    // Line sampler and packet control
    logic       d_in;
    logic       bit_strobe;
    logic       enable;
    logic       clear;

    // Accepted-bit stream toward the bit/byte counter
    logic       shift_enable;
    logic       rcv_bit;
    logic [7:0] shift_data;
    logic       stuffed;
    logic       stuff_err;

    modport master (
        output d_in,
        output bit_strobe,
        output enable,
        output clear,
        input  shift_enable,
        input  rcv_bit,
        input  shift_data,
        input  stuffed,
        input  stuff_err
    );

    modport slave (
        input  d_in,
        input  bit_strobe,
        input  enable,
        input  clear,
        output shift_enable,
        output rcv_bit,
        output shift_data,
        output stuffed,
        output stuff_err
    );
endinterface

// File: rtl/rx_nrzi_destuff.sv
// NRZI decoder and zero de-stuffer feeding the receive bit/byte counter.
// Every sampled line bit is NRZI-decoded; after STUFF_LEN consecutive decoded
// ones the next bit must be a stuffed zero, which is dropped without a
// shift_enable pulse so the downstream counter never advances on it. A decoded
// one in that slot is a stuff violation and parks the block in ERR until clear.
// Accepted bits enter shift_data at bit 7 (LSB-first assembly).
module rx_nrzi_destuff #(
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   STUFF_LEN  = 6
) (
    input  logic             clk,
    input  logic             rst,
    rx_nrzi_destuff_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Run length at which the next bit is the stuffed zero (legal 2..7, fits 3 bits)
    localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN);

    state_t     state;
    logic       prev_level;
    logic [2:0] ones;

    // Registered outputs; vld_p0 is the accepted-bit strobe toward the counter
    logic       vld_p0;
    logic       rcv_bit_p0;
    logic [7:0] shift_data_p0;
    logic       stuffed_p0;
    logic       stuff_err_p0;

    logic       dec_bit;
    logic       at_limit;

    // NRZI: no transition means 1, a transition means 0
    function automatic logic nrzi_decode(input logic level, input logic prev);
        return (level == prev);
    endfunction

    // Ones run length after an accepted bit; a zero restarts the run
    function automatic logic [2:0] ones_next(input logic bit_val, input logic [2:0] cnt);
        return bit_val ? (cnt + 3'd1) : 3'd0;
    endfunction

    // Decode the current line sample and flag a full run of ones
    always_comb begin
        dec_bit  = nrzi_decode(bus.d_in, prev_level);
        at_limit = (ones >= STUFF_MAX);
    end

    // Control FSM, decode history and registered outputs in one clocked process
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            prev_level    <= IDLE_LEVEL;
            ones          <= 3'd0;
            vld_p0        <= 1'b0;
            rcv_bit_p0    <= 1'b0;
            shift_data_p0 <= 8'h00;
            stuffed_p0    <= 1'b0;
            stuff_err_p0  <= 1'b0;
        end else if (bus.clear) begin
            // Per-packet restart: a strobe in this cycle is discarded, rcv_bit holds
            state         <= IDLE;
            prev_level    <= IDLE_LEVEL;
            ones          <= 3'd0;
            vld_p0        <= 1'b0;
            shift_data_p0 <= 8'h00;
            stuffed_p0    <= 1'b0;
            stuff_err_p0  <= 1'b0;
        end else begin
            vld_p0     <= 1'b0;
            stuffed_p0 <= 1'b0;

            // Line history tracks every strobe regardless of state
            if (bus.bit_strobe) begin
                prev_level <= bus.d_in;
            end

            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state <= RUN;
                        ones  <= 3'd0;
                    end
                end

                RUN: begin
                    if (bus.bit_strobe) begin
                        if (!at_limit) begin
                            vld_p0        <= 1'b1;
                            rcv_bit_p0    <= dec_bit;
                            shift_data_p0 <= {dec_bit, shift_data_p0[7:1]};
                            ones          <= ones_next(dec_bit, ones);
                        end else if (!dec_bit) begin
                            // Expected stuffed zero: drop it silently
                            stuffed_p0 <= 1'b1;
                            ones       <= 3'd0;
                        end else begin
                            // One where a stuffed zero was required; ones holds
                            stuff_err_p0 <= 1'b1;
                        end
                    end

                    // The strobe of this cycle is processed first; a violation
                    // outranks enable dropping in the same cycle
                    if (bus.bit_strobe && at_limit && dec_bit) begin
                        state <= ERR;
                    end else if (!bus.enable) begin
                        state <= IDLE;
                    end
                end

                ERR: begin
                    // Only clear or rst leave ERR
                    state <= ERR;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.shift_enable = vld_p0;
    assign bus.rcv_bit      = rcv_bit_p0;
    assign bus.shift_data   = shift_data_p0;
    assign bus.stuffed      = stuffed_p0;
    assign bus.stuff_err    = stuff_err_p0;

endmodule

// File: tb/tb_rx_nrzi_destuff.sv
// Testbench for rx_nrzi_destuff: stimulus/expectation table plus a reset-mid-byte
// sequence, with expectations queued at drive time and popped when the DUT
// outputs are sampled one cycle later.
module tb_rx_nrzi_destuff;

    logic clk;
    logic rst;

    rx_nrzi_destuff_if bus ();

    rx_nrzi_destuff #(
        .IDLE_LEVEL (1'b1),
        .STUFF_LEN  (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         seg;
        logic       rst;
        logic       clr;
        logic       en;
        logic       stb;
        logic       d;
        logic       se;
        logic       rb;
        logic [7:0] sd;
        logic       st;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    int tests;
    int failed;
    int pulse_cnt[7];
    int stuff_cnt[7];

    function automatic vec_t mk(input int seg, input logic r, input logic c, input logic e,
                                input logic s, input logic d, input logic se, input logic rb,
                                input logic [7:0] sd, input logic st, input logic err);
        vec_t v;
        v.seg = seg; v.rst = r; v.clr = c; v.en = e; v.stb = s; v.d = d;
        v.se = se; v.rb = rb; v.sd = sd; v.st = st; v.err = err;
        return v;
    endfunction

    function automatic void add(input int seg, input logic r, input logic c, input logic e,
                                input logic s, input logic d, input logic se, input logic rb,
                                input logic [7:0] sd, input logic st, input logic err);
        vecs.push_back(mk(seg, r, c, e, s, d, se, rb, sd, st, err));
    endfunction

    // Drive one cycle of stimulus, queue its expectation, check after the edge
    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst            = v.rst;
        bus.clear      = v.clr;
        bus.enable     = v.en;
        bus.bit_strobe = v.stb;
        bus.d_in       = v.d;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL scoreboard: got empty queue, want one pending entry");
        end else begin
            e = exp_q.pop_front();
            if (bus.shift_enable !== e.se || bus.rcv_bit !== e.rb || bus.shift_data !== e.sd ||
                bus.stuffed !== e.st || bus.stuff_err !== e.err) begin
                failed++;
                $display("FAIL seg%0d vec: got se=%b rb=%b sd=%h st=%b err=%b, want se=%b rb=%b sd=%h st=%b err=%b",
                         e.seg, bus.shift_enable, bus.rcv_bit, bus.shift_data, bus.stuffed,
                         bus.stuff_err, e.se, e.rb, e.sd, e.st, e.err);
            end
            if (bus.shift_enable === 1'b1) pulse_cnt[e.seg]++;
            if (bus.stuffed === 1'b1) stuff_cnt[e.seg]++;
        end
    endtask

    task automatic check_count(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    int exp_pulses[7] = '{0, 8, 7, 6, 3, 16, 2};
    int exp_stuff[7]  = '{0, 0, 1, 0, 0, 1, 0};

    initial begin
        rst = 1'b1; bus.clear = 1'b0; bus.enable = 1'b0; bus.bit_strobe = 1'b0; bus.d_in = 1'b1;
        tests = 0; failed = 0;
        for (int i = 0; i < 7; i++) begin pulse_cnt[i] = 0; stuff_cnt[i] = 0; end

        // seg 0: reset held with strobes active, then idle strobe
        add(0, 1,0,1,1,0, 0,0,8'h00,0,0);
        add(0, 1,0,1,1,0, 0,0,8'h00,0,0);
        add(0, 0,0,0,0,0, 0,0,8'h00,0,0);
        add(0, 0,0,0,1,1, 0,0,8'h00,0,0);

        // seg 1: NRZI decode 1,0,0,1,1,0,1,0 -> bits 1,0,1,0,1,0,0,0 -> 8'h15
        add(1, 0,0,1,0,0, 0,0,8'h00,0,0);
        add(1, 0,0,1,1,1, 1,1,8'h80,0,0);
        add(1, 0,0,1,1,0, 1,0,8'h40,0,0);
        add(1, 0,0,1,1,0, 1,1,8'hA0,0,0);
        add(1, 0,0,1,1,1, 1,0,8'h50,0,0);
        add(1, 0,0,1,1,1, 1,1,8'hA8,0,0);
        add(1, 0,0,1,1,0, 1,0,8'h54,0,0);
        add(1, 0,0,1,1,1, 1,0,8'h2A,0,0);
        add(1, 0,0,1,1,0, 1,0,8'h15,0,0);

        // seg 2: six ones, stuffed zero dropped, then a real zero -> 8'h7E
        add(2, 0,1,1,0,0, 0,0,8'h00,0,0);
        add(2, 0,0,1,0,0, 0,0,8'h00,0,0);
        add(2, 0,0,1,1,1, 1,1,8'h80,0,0);
        add(2, 0,0,1,1,1, 1,1,8'hC0,0,0);
        add(2, 0,0,1,1,1, 1,1,8'hE0,0,0);
        add(2, 0,0,1,1,1, 1,1,8'hF0,0,0);
        add(2, 0,0,1,1,1, 1,1,8'hF8,0,0);
        add(2, 0,0,1,1,1, 1,1,8'hFC,0,0);
        add(2, 0,0,1,1,0, 0,1,8'hFC,1,0);
        add(2, 0,0,1,1,1, 1,0,8'h7E,0,0);
        add(2, 0,0,1,0,1, 0,0,8'h7E,0,0);

        // seg 3: seven ones -> violation, ERR ignores strobes/enable until clear
        add(3, 0,1,1,0,1, 0,0,8'h00,0,0);
        add(3, 0,0,1,0,1, 0,0,8'h00,0,0);
        for (int i = 0; i < 6; i++) add(3, 0,0,1,1,1, 1,1,8'hFC << (5 - i),0,0);
        add(3, 0,0,1,1,1, 0,1,8'hFC,0,1);
        for (int i = 0; i < 8; i++) add(3, 0,0,1,1,logic'(i & 1), 0,1,8'hFC,0,1);
        add(3, 0,0,0,0,0, 0,1,8'hFC,0,1);
        add(3, 0,1,0,0,0, 0,1,8'h00,0,0);
        add(3, 0,0,0,0,0, 0,1,8'h00,0,0);

        // seg 4: clear with strobe discards it; enable falling with strobe
        add(4, 0,0,1,0,0, 0,1,8'h00,0,0);
        add(4, 0,0,1,1,0, 1,0,8'h00,0,0);
        add(4, 0,1,1,1,0, 0,0,8'h00,0,0);
        add(4, 0,0,1,0,0, 0,0,8'h00,0,0);
        add(4, 0,0,1,1,1, 1,1,8'h80,0,0);
        add(4, 0,0,0,1,1, 1,1,8'hC0,0,0);
        add(4, 0,0,0,1,0, 0,1,8'hC0,0,0);
        add(4, 0,0,0,1,0, 0,1,8'hC0,0,0);

        // seg 5: byte 8'hFD ending in six ones, stuffed zero, byte 8'h96
        add(5, 0,1,1,0,0, 0,1,8'h00,0,0);
        add(5, 0,0,1,0,0, 0,1,8'h00,0,0);
        add(5, 0,0,1,1,1, 1,1,8'h80,0,0);
        add(5, 0,0,1,1,0, 1,0,8'h40,0,0);
        add(5, 0,0,1,1,0, 1,1,8'hA0,0,0);
        add(5, 0,0,1,1,0, 1,1,8'hD0,0,0);
        add(5, 0,0,1,1,0, 1,1,8'hE8,0,0);
        add(5, 0,0,1,1,0, 1,1,8'hF4,0,0);
        add(5, 0,0,1,1,0, 1,1,8'hFA,0,0);
        add(5, 0,0,1,1,0, 1,1,8'hFD,0,0);
        add(5, 0,0,1,1,1, 0,1,8'hFD,1,0);
        add(5, 0,0,1,1,0, 1,0,8'h7E,0,0);
        add(5, 0,0,1,1,0, 1,1,8'hBF,0,0);
        add(5, 0,0,1,1,0, 1,1,8'hDF,0,0);
        add(5, 0,0,1,1,1, 1,0,8'h6F,0,0);
        add(5, 0,0,1,1,1, 1,1,8'hB7,0,0);
        add(5, 0,0,1,1,0, 1,0,8'h5B,0,0);
        add(5, 0,0,1,1,1, 1,0,8'h2D,0,0);
        add(5, 0,0,1,1,1, 1,1,8'h96,0,0);

        foreach (vecs[i]) step(vecs[i]);

        // seg 6: rst mid-byte with a strobe; IDLE strobe only seeds prev_level
        step(mk(6, 0,0,1,1,1, 1,1,8'hCB,0,0));
        step(mk(6, 1,0,1,1,0, 0,0,8'h00,0,0));
        step(mk(6, 0,0,1,1,1, 0,0,8'h00,0,0));
        step(mk(6, 0,0,1,1,1, 1,1,8'h80,0,0));

        for (int i = 0; i < 7; i++) begin
            check_count($sformatf("pulses_seg%0d", i), pulse_cnt[i], exp_pulses[i]);
            check_count($sformatf("stuffed_seg%0d", i), stuff_cnt[i], exp_stuff[i]);
        end
        check_count("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Bound on total run time
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want finish before 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rx_nrzi_destuff.md
# rx_nrzi_destuff

Receive-path stage sitting directly upstream of the 25-count bit/byte counter. Each sampled line bit is NRZI-decoded, stuffed zeros following six consecutive ones are removed, and received bits are assembled LSB-first into an 8-bit shift register. The block issues exactly one `shift_enable` pulse per real (non-stuffed) data bit; that pulse drives the counter's `count_enable`. Stuffed bits are dropped and produce no pulse, so the counter never advances on them.

## Interface
- `IDLE_LEVEL`, default 1'b1: line level assumed before the first bit, and reload value of the previous-level register.
- `STUFF_LEN`, default 6: number of consecutive decoded 1s after which a stuffed 0 is expected. Legal range is 2–7.
- `clk`  in  1  System clock. All logic is on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `d_in`  in  1  Line bit, already synchronized to `clk`.
- `bit_strobe`  in  1  One-cycle pulse marking the sample point of each line bit. It may be high on consecutive cycles.
- `enable`  in  1  Packet reception active.
- `clear`  in  1  Synchronous per-packet restart.
- `shift_enable`  out  1  One-cycle pulse for each accepted data bit. Feeds the counter's `count_enable`.
- `rcv_bit`  out  1  Decoded value of the last accepted bit. Valid while `shift_enable` is high and held afterwards.
- `shift_data`  out  8  Last 8 accepted bits, LSB-first. Each accepted bit enters at bit 7 and older bits shift toward bit 0.
- `stuffed`  out  1  One-cycle pulse when a stuffed bit is dropped.
- `stuff_err`  out  1  Sticky flag: a decoded 1 arrived where a stuffed 0 was required.

## Operation
- State machine: IDLE, RUN, ERR.
  - IDLE → RUN when `enable`=1. The ones counter is zeroed on this transition.
  - RUN → IDLE when `enable`=0.
  - RUN → ERR on a stuff violation.
  - ERR → IDLE only on `clear` or `rst`. `enable` has no effect in ERR.
- NRZI decode happens on every `bit_strobe` in every state:
  - decoded bit = 1 if `d_in` equals `prev_level`, 0 if they differ.
  - `prev_level` is then loaded with `d_in`.
  - In IDLE and ERR only `prev_level` updates; no other state changes.
- RUN, on each strobe, with `ones` as a 3-bit counter:
  - decoded 1 and `ones` < `STUFF_LEN`: accept the bit and increment `ones`.
  - decoded 0 and `ones` < `STUFF_LEN`: accept the bit and zero `ones`.
  - decoded 0 and `ones` = `STUFF_LEN`: drop the bit, pulse `stuffed`, zero `ones`. `shift_enable` stays low.
  - decoded 1 and `ones` = `STUFF_LEN`: drop the bit, set `stuff_err`, enter ERR. `ones` holds at `STUFF_LEN`.
- An accepted bit does all of the following on the same edge:
  - `shift_enable` pulses.
  - `rcv_bit` loads the decoded bit.
  - `shift_data` loads {decoded, `shift_data`[7:1]}.
- A stuff bit may arrive across a byte boundary. It is still dropped, and the downstream count is unaffected.
- `clear` (synchronous) sets:
  - state to IDLE
  - `ones` = 0
  - `prev_level` = `IDLE_LEVEL`
  - `stuff_err` = 0
  - `shift_data` = 8'h00

  `rcv_bit` holds.
- Priority: `rst` > `clear` > `bit_strobe` processing > `enable` transitions.
  - A strobe in the same cycle as `clear` is discarded entirely, including its effect on `prev_level`.
  - When `enable` falls in the same cycle as a strobe while in RUN, that strobe is still processed as RUN, then the state moves to IDLE.

## Timing
- `rst` values: state IDLE, `prev_level` = `IDLE_LEVEL`, `ones` = 0, `shift_enable` = 0, `rcv_bit` = 0, `shift_data` = 8'h00, `stuffed` = 0, `stuff_err` = 0.
- All outputs are registered.
- Latency is 1 cycle: strobe sampled at edge N → `shift_enable`, `stuffed` and the updated data are visible after edge N and held for exactly one cycle. Pulses deassert at edge N+1 unless another strobe was sampled.
- Back-to-back strobes produce back-to-back pulses. No throughput limit.
- `stuff_err` rises 1 cycle after the violating strobe and stays high until `clear` or `rst`.
- `rst` or `clear` mid-byte: no pulse after the reset/clear edge. Processing resumes with the first strobe sampled on or after the cycle following `rst`/`clear` deassertion, once `enable` has moved the state to RUN.

## Test plan
- **Reset:** hold `rst` 2 cycles with strobes active. Required: all outputs 0 and `shift_data` = 8'h00 during and after reset. No `shift_enable` until the first strobe in RUN.
- **NRZI decode:** `enable`=1, `IDLE_LEVEL`=1, `d_in` = 1,0,0,1,1,0,1,0 on 8 strobes. Required:
  - decoded bits 1,0,1,0,1,0,0,0
  - 8 `shift_enable` pulses
  - `shift_data` = 8'h15
- **Stuff removal:** six decoded 1s, then a decoded 0, then a decoded 0. Required:
  - 6 pulses, then `stuffed`=1 with `shift_enable`=0, then 1 pulse with `rcv_bit`=0
  - 7 pulses total, `shift_data` = 8'h7E
- **Stuff violation:** seven decoded 1s, then 8 more strobes. Required:
  - `stuff_err`=1, 1 cycle after the 7th strobe
  - exactly 6 pulses in total
  - state ERR until `clear`, after which `stuff_err`=0
- **Simultaneous events:**
  - `clear` and `bit_strobe` in the same cycle: no pulse, and `prev_level` = 1 afterwards.
  - `enable` falling with a strobe: that bit is accepted, later strobes produce no pulse.
- **Boundary/stuffing across bytes:** 8 data bits, the last 6 of them decoded 1s, then a stuffed 0, then 8 more bits. Required: 16 pulses and 1 `stuffed` pulse, and the second byte in `shift_data` is exact.
